axi_sram_slave: RTL and testbench

//  AXI4 responder that bridges one bus slave port to a single-port synchronous SRAM
//  (IM/DM/ROM macros). It is the counterpart of the CPU-side Master blocks.

---
 rtl/axi_pkg.sv | 25 ++
 rtl/axi_sram_slave.sv | 182 ++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI response/burst codes and SRAM slave state encoding
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_WORD   = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_R_ISSUE,
    ST_R_DATA,
    ST_W_DATA,
    ST_B_RESP
  } state_t;

  function automatic logic burst_supported(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

endpackage

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI4 responder bridging one slave port to a single-port sync SRAM
// One transaction in flight; reads take an issue cycle plus a data cycle per beat.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int ID_W    = 8,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 4,
  parameter int SRAM_AW = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_W-1:0]     ARID,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [LEN_W-1:0]    ARLEN,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [ID_W-1:0]     RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [LEN_W-1:0]    AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  output logic                CEB,
  output logic [DATA_W/8-1:0] WEB,
  output logic [SRAM_AW-1:0]  A,
  output logic [DATA_W-1:0]   DI,
  input  logic [DATA_W-1:0]   DO
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [SRAM_AW-1:0] ADDR_ONE = 1;
  localparam logic [LEN_W-1:0]   LEN_ONE  = 1;

  state_t               r_state;
  state_t               w_next;
  logic                 r_rr;
  logic [ID_W-1:0]      r_id;
  logic [SRAM_AW-1:0]   r_addr;
  logic [LEN_W-1:0]     r_len;
  logic [LEN_W-1:0]     r_cnt;
  logic [1:0]           r_burst;
  logic                 r_bad_burst;
  logic                 r_err;
  logic                 r_first;
  logic [DATA_W-1:0]    r_rdata;

  logic w_idle;
  logic w_ar_hs;
  logic w_aw_hs;
  logic w_last;
  logic w_w_beat;
  logic w_step;
  logic w_unused_addr;

  assign w_idle  = (r_state == ST_IDLE);
  // r_rr=0 favours the read channel when both address valids collide
  assign ARREADY = w_idle & ARVALID & (~AWVALID | ~r_rr);
  assign AWREADY = w_idle & AWVALID & (~ARVALID | r_rr);
  assign w_ar_hs = ARVALID & ARREADY;
  assign w_aw_hs = AWVALID & AWREADY;

  assign w_last   = (r_cnt == r_len);
  assign w_w_beat = (r_state == ST_W_DATA) & WVALID;
  assign w_step   = ((r_state == ST_R_DATA) & RREADY) | w_w_beat;

  // DO is only valid in the first data cycle; afterwards the captured copy is replayed
  assign RDATA = r_first ? (r_bad_burst ? '0 : DO) : r_rdata;
  assign RID   = r_id;
  assign BID   = r_id;
  assign RRESP = r_err ? RESP_SLVERR : RESP_OKAY;
  assign BRESP = r_err ? RESP_SLVERR : RESP_OKAY;
  assign A     = r_addr;

  assign w_unused_addr = ^{ARADDR[ADDR_W-1:SRAM_AW+2], ARADDR[1:0],
                           AWADDR[ADDR_W-1:SRAM_AW+2], AWADDR[1:0]};

  always_comb begin
    w_next = r_state;
    CEB    = 1'b1;
    WEB    = '1;
    DI     = '0;
    RVALID = 1'b0;
    RLAST  = 1'b0;
    WREADY = 1'b0;
    BVALID = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ar_hs)      w_next = ST_R_ISSUE;
        else if (w_aw_hs) w_next = ST_W_DATA;
      end
      ST_R_ISSUE: begin
        CEB    = 1'b0;
        w_next = ST_R_DATA;
      end
      ST_R_DATA: begin
        RVALID = 1'b1;
        RLAST  = w_last;
        if (RREADY) w_next = w_last ? ST_IDLE : ST_R_ISSUE;
      end
      ST_W_DATA: begin
        WREADY = 1'b1;
        if (WVALID) begin
          // unsupported burst types run their beats without touching the macro
          CEB = r_bad_burst;
          WEB = r_bad_burst ? {STRB_W{1'b1}} : ~WSTRB;
          DI  = WDATA;
          if (w_last) w_next = ST_B_RESP;
        end
      end
      ST_B_RESP: begin
        BVALID = 1'b1;
        if (BREADY) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rr        <= 1'b0;
      r_id        <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_burst     <= BURST_FIXED;
      r_bad_burst <= 1'b0;
      r_err       <= 1'b0;
      r_first     <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state <= w_next;
      r_first <= (r_state == ST_R_ISSUE);
      if (r_state == ST_R_DATA) r_rdata <= RDATA;
      if (w_ar_hs) begin
        r_rr        <= ~r_rr;
        r_id        <= ARID;
        r_addr      <= ARADDR[SRAM_AW+1:2];
        r_len       <= ARLEN;
        r_cnt       <= '0;
        r_burst     <= ARBURST;
        r_bad_burst <= ~burst_supported(ARBURST);
        r_err       <= ~burst_supported(ARBURST) | (ARSIZE != SIZE_WORD);
      end else if (w_aw_hs) begin
        r_rr        <= ~r_rr;
        r_id        <= AWID;
        r_addr      <= AWADDR[SRAM_AW+1:2];
        r_len       <= AWLEN;
        r_cnt       <= '0;
        r_burst     <= AWBURST;
        r_bad_burst <= ~burst_supported(AWBURST);
        r_err       <= ~burst_supported(AWBURST) | (AWSIZE != SIZE_WORD);
      end else if (w_step) begin
        r_cnt <= r_cnt + LEN_ONE;
        if (r_burst == BURST_INCR) r_addr <= r_addr + ADDR_ONE;
        // the burst length comes from AWLEN; a misplaced WLAST only taints the response
        if (w_w_beat && (WLAST != w_last)) r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - self-checking bench for axi_sram_slave with SRAM and reference memory models
module tb_axi_sram_slave;
  import axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ARID = '0;
  logic [31:0] ARADDR = '0;
  logic [3:0]  ARLEN = '0;
  logic [2:0]  ARSIZE = '0;
  logic [1:0]  ARBURST = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [7:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY = 1'b0;
  logic [7:0]  AWID = '0;
  logic [31:0] AWADDR = '0;
  logic [3:0]  AWLEN = '0;
  logic [2:0]  AWSIZE = '0;
  logic [1:0]  AWBURST = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WLAST = 1'b0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [7:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic        CEB;
  logic [3:0]  WEB;
  logic [13:0] A;
  logic [31:0] DI;
  logic [31:0] DO = '0;

  logic [31:0] sram    [0:16383];
  logic [31:0] ref_mem [0:16383];

  int checks = 0;
  int errors = 0;
  int grants = 0;

  typedef struct {
    bit          wr;
    logic [7:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  strb;
    logic [31:0] data;
    bit          bad_last;
    logic [1:0]  exp_resp;
    bit          chk_d0;
    logic [31:0] exp_d0;
  } vec_t;

  vec_t vecs[$];

  axi_sram_slave dut (
    .clk(clk), .rst(rst),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .CEB(CEB), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!CEB) begin
      if (&WEB) DO <= sram[A];
      else for (int k = 0; k < 4; k++) if (!WEB[k]) sram[A][8*k +: 8] <= DI[8*k +: 8];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(bit wr, logic [7:0] id, logic [31:0] addr, logic [3:0] len,
                              logic [2:0] size, logic [1:0] burst, logic [3:0] strb,
                              logic [31:0] data, bit bad_last, logic [1:0] exp_resp,
                              bit chk_d0, logic [31:0] exp_d0);
    vec_t v;
    v.wr = wr; v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.strb = strb; v.data = data; v.bad_last = bad_last; v.exp_resp = exp_resp;
    v.chk_d0 = chk_d0; v.exp_d0 = exp_d0;
    return v;
  endfunction

  task automatic addr_phase(input bit wr, input logic [7:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    if (wr) begin
      AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    end else begin
      ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    end
    #1;
    while (!(wr ? AWREADY : ARREADY) && n < 20) begin @(negedge clk); n++; end
    chk("addr_ready", wr ? AWREADY : ARREADY, 1);
    @(negedge clk);
    AWVALID = 1'b0; ARVALID = 1'b0;
    grants++;
  endtask

  task automatic read_beats(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int stall0,
                            input int stall_n, output logic [31:0] d0, output logic [1:0] resp);
    logic [13:0] word;
    logic [31:0] exp;
    logic [1:0]  er;
    bit          bad;
    int          n;
    word = addr[15:2];
    bad  = !(burst == BURST_FIXED || burst == BURST_INCR);
    er   = (bad || size != 3'b010) ? 2'b10 : 2'b00;
    d0   = '0;
    resp = '0;
    chk("r_issue_rvalid", RVALID, 0);
    chk("r_issue_ceb", CEB, 0);
    chk("r_issue_web", WEB, 4'hF);
    chk("r_issue_a", A, word);
    @(negedge clk);
    chk("r_latency", RVALID, 1);
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (!RVALID && n < 20) begin @(negedge clk); n++; end
      exp = bad ? 32'h0 : ref_mem[word];
      chk("r_data", RDATA, exp);
      chk("r_last", RLAST, b == int'(len));
      chk("r_resp", RRESP, er);
      chk("r_id", RID, id);
      if (b == 0) d0 = RDATA;
      resp = RRESP;
      for (int s = 0; s < ((b == 0) ? stall0 : stall_n); s++) begin
        @(negedge clk);
        chk("r_hold_valid", RVALID, 1);
        chk("r_hold_data", RDATA, exp);
        chk("r_hold_last", RLAST, b == int'(len));
        chk("r_hold_ceb", CEB, 1);
      end
      RREADY = 1'b1;
      @(negedge clk);
      RREADY = 1'b0;
      if (burst == BURST_INCR) word++;
    end
    chk("r_done", RVALID, 0);
  endtask

  task automatic write_beats(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                             input logic [31:0] data, input bit bad_last, input int bstall,
                             output logic [1:0] resp);
    logic [13:0] word;
    logic [31:0] wd;
    logic [3:0]  exp_web;
    logic [1:0]  er;
    bit          bad;
    int          n;
    word    = addr[15:2];
    bad     = !(burst == BURST_FIXED || burst == BURST_INCR);
    er      = (bad || size != 3'b010 || bad_last) ? 2'b10 : 2'b00;
    exp_web = bad ? 4'hF : ~strb;
    for (int b = 0; b <= int'(len); b++) begin
      wd = data + 32'(b);
      WDATA = wd; WSTRB = strb;
      WLAST = (b == int'(len)) ^ (bad_last && b == 0);
      WVALID = 1'b1;
      #1;
      n = 0;
      while (!WREADY && n < 20) begin @(negedge clk); n++; end
      chk("w_ready", WREADY, 1);
      chk("w_ceb", CEB, bad);
      chk("w_web", WEB, exp_web);
      if (!bad) begin
        chk("w_a", A, word);
        chk("w_di", DI, wd);
        for (int k = 0; k < 4; k++) if (strb[k]) ref_mem[word][8*k +: 8] = wd[8*k +: 8];
      end
      @(negedge clk);
      if (burst == BURST_INCR) word++;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    chk("b_valid", BVALID, 1);
    chk("b_id", BID, id);
    chk("b_resp", BRESP, er);
    resp = BRESP;
    for (int s = 0; s < bstall; s++) begin
      @(negedge clk);
      chk("b_hold_valid", BVALID, 1);
      chk("b_hold_ceb", CEB, 1);
    end
    BREADY = 1'b1;
    @(negedge clk);
    BREADY = 1'b0;
    chk("b_done", BVALID, 0);
  endtask

  initial begin
    logic [31:0] d0;
    logic [1:0]  resp;
    logic [31:0] seed;
    logic [31:0] raddr;
    logic [3:0]  rlen;
    logic [2:0]  rsize;
    logic [1:0]  rburst;
    bit          exp_rd;
    int          n;
    int          r;

    for (int i = 0; i < 16384; i++) begin
      seed = 32'(i) * 32'h9E3779B9 ^ 32'h5A5A_0F0F;
      sram[i] = seed;
      ref_mem[i] = seed;
    end
    sram[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;

    repeat (3) @(negedge clk);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_wready", WREADY, 0);
    chk("rst_ceb", CEB, 1);
    chk("rst_web", WEB, 4'hF);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_arready", ARREADY, 0);
    chk("idle_awready", AWREADY, 0);
    chk("idle_rdata", RDATA, 0);
    chk("idle_a", A, 0);
    chk("idle_di", DI, 0);
    chk("idle_rlast", RLAST, 0);

    // reset in the middle of a read burst
    addr_phase(0, 8'h44, 32'h100, 4'd3, 3'd2, BURST_INCR);
    n = 0;
    while (!RVALID && n < 20) begin @(negedge clk); n++; end
    chk("t1_rvalid", RVALID, 1);
    rst = 1'b1;
    #1;
    chk("t1_rst_rvalid", RVALID, 0);
    chk("t1_rst_ceb", CEB, 1);
    chk("t1_rst_web", WEB, 4'hF);
    @(negedge clk);
    rst = 1'b0;
    grants = 0;
    repeat (3) begin
      @(negedge clk);
      chk("t1_quiet_ceb", CEB, 1);
    end

    addr_phase(0, 8'h5A, 32'h10, 4'd0, 3'd2, BURST_INCR);
    read_beats(8'h5A, 32'h10, 4'd0, 3'd2, BURST_INCR, 0, 0, d0, resp);
    chk("t2_data", d0, 32'hDEADBEEF);
    chk("t2_resp", resp, 2'b00);

    vecs.push_back(mk(1, 8'h01, 32'h100,  4'd3, 3'd2, BURST_INCR,  4'hF, 32'h1,        0, 2'b00, 0, 0));
    vecs.push_back(mk(0, 8'h02, 32'h100,  4'd3, 3'd2, BURST_INCR,  4'hF, 0,            0, 2'b00, 1, 32'h1));
    vecs.push_back(mk(1, 8'h03, 32'h200,  4'd0, 3'd2, BURST_INCR,  4'hF, 32'h11223344, 0, 2'b00, 0, 0));
    vecs.push_back(mk(1, 8'h04, 32'h200,  4'd0, 3'd2, BURST_INCR,  4'h2, 32'hAABBCCDD, 0, 2'b00, 0, 0));
    vecs.push_back(mk(0, 8'h05, 32'h200,  4'd0, 3'd2, BURST_INCR,  4'hF, 0,            0, 2'b00, 1, 32'h1122CC44));
    vecs.push_back(mk(1, 8'h06, 32'h100,  4'd1, 3'd2, BURST_WRAP,  4'hF, 32'hFFFFFFFF, 0, 2'b10, 0, 0));
    vecs.push_back(mk(0, 8'h07, 32'h100,  4'd0, 3'd2, BURST_INCR,  4'hF, 0,            0, 2'b00, 1, 32'h1));
    vecs.push_back(mk(0, 8'h08, 32'h100,  4'd1, 3'd2, BURST_WRAP,  4'hF, 0,            0, 2'b10, 1, 32'h0));
    vecs.push_back(mk(0, 8'h09, 32'h104,  4'd0, 3'd1, BURST_INCR,  4'hF, 0,            0, 2'b10, 1, 32'h2));
    vecs.push_back(mk(1, 8'h0A, 32'h300,  4'd2, 3'd2, BURST_FIXED, 4'hF, 32'h50,       0, 2'b00, 0, 0));
    vecs.push_back(mk(0, 8'h0B, 32'h300,  4'd1, 3'd2, BURST_FIXED, 4'hF, 0,            0, 2'b00, 1, 32'h52));
    vecs.push_back(mk(1, 8'h0C, 32'hFFFC, 4'd1, 3'd2, BURST_INCR,  4'hF, 32'h77,       0, 2'b00, 0, 0));
    vecs.push_back(mk(0, 8'h0D, 32'h0,    4'd0, 3'd2, BURST_INCR,  4'hF, 0,            0, 2'b00, 1, 32'h78));
    vecs.push_back(mk(1, 8'h0E, 32'h400,  4'd1, 3'd2, BURST_INCR,  4'hF, 32'h9,        1, 2'b10, 0, 0));
    vecs.push_back(mk(0, 8'h0F, 32'h400,  4'd1, 3'd2, BURST_INCR,  4'hF, 0,            0, 2'b00, 1, 32'h9));
    vecs.push_back(mk(1, 8'h10, 32'h500,  4'd0, 3'd2, 2'b11,       4'hF, 32'hCAFE,     0, 2'b10, 0, 0));
    vecs.push_back(mk(1, 8'h11, 32'h500,  4'd0, 3'd2, BURST_INCR,  4'h0, 32'h1234,     0, 2'b00, 0, 0));
    vecs.push_back(mk(0, 8'h12, 32'h500,  4'd0, 3'd2, BURST_INCR,  4'hF, 0,            0, 2'b00, 0, 0));
    vecs.push_back(mk(1, 8'h13, 32'h600,  4'd0, 3'd1, BURST_INCR,  4'hF, 32'h66,       0, 2'b10, 0, 0));
    vecs.push_back(mk(0, 8'h14, 32'h600,  4'd0, 3'd2, BURST_INCR,  4'hF, 0,            0, 2'b00, 1, 32'h66));

    foreach (vecs[i]) begin
      addr_phase(vecs[i].wr, vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst);
      if (vecs[i].wr) begin
        write_beats(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst,
                    vecs[i].strb, vecs[i].data, vecs[i].bad_last, 0, resp);
      end else begin
        read_beats(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst,
                   0, 0, d0, resp);
        if (vecs[i].chk_d0) chk("tbl_d0", d0, vecs[i].exp_d0);
      end
      chk("tbl_resp", resp, vecs[i].exp_resp);
    end

    // backpressure on read beat and on the write response
    addr_phase(0, 8'h21, 32'h100, 4'd3, 3'd2, BURST_INCR);
    read_beats(8'h21, 32'h100, 4'd3, 3'd2, BURST_INCR, 5, 1, d0, resp);
    addr_phase(1, 8'h22, 32'h700, 4'd0, 3'd2, BURST_INCR);
    write_beats(8'h22, 32'h700, 4'd0, 3'd2, BURST_INCR, 4'hF, 32'h700, 0, 5, resp);

    // simultaneous AR/AW: the losing request is withdrawn so the two rounds see alternate priority
    for (int rnd = 0; rnd < 2; rnd++) begin
      exp_rd = (grants % 2 == 0);
      ARID = 8'h30; ARADDR = 32'h100; ARLEN = 4'd0; ARSIZE = 3'd2; ARBURST = BURST_INCR;
      AWID = 8'h31; AWADDR = 32'h704; AWLEN = 4'd0; AWSIZE = 3'd2; AWBURST = BURST_INCR;
      ARVALID = 1'b1; AWVALID = 1'b1;
      #1;
      chk("grant_arready", ARREADY, exp_rd);
      chk("grant_awready", AWREADY, !exp_rd);
      @(negedge clk);
      ARVALID = 1'b0; AWVALID = 1'b0;
      grants++;
      if (exp_rd) read_beats(8'h30, 32'h100, 4'd0, 3'd2, BURST_INCR, 0, 0, d0, resp);
      else write_beats(8'h31, 32'h704, 4'd0, 3'd2, BURST_INCR, 4'hF, 32'h7040 + 32'(rnd), 0, 0, resp);
    end

    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 7);
      raddr = (r == 0) ? (32'h0000FFE0 + ($urandom_range(0, 7) << 2)) : ($urandom_range(0, 63) << 2);
      rlen  = 4'($urandom_range(0, 15));
      rsize = ($urandom_range(0, 9) == 0) ? 3'd1 : 3'd2;
      r = $urandom_range(0, 9);
      rburst = (r == 0) ? BURST_WRAP : (r == 1) ? 2'b11 : (r < 4) ? BURST_FIXED : BURST_INCR;
      if ($urandom_range(0, 1) == 1) begin
        addr_phase(1, 8'(t), raddr, rlen, rsize, rburst);
        write_beats(8'(t), raddr, rlen, rsize, rburst, 4'($urandom_range(0, 15)), $urandom,
                    ($urandom_range(0, 9) == 0), $urandom_range(0, 2), resp);
      end else begin
        addr_phase(0, 8'(t), raddr, rlen, rsize, rburst);
        read_beats(8'(t), raddr, rlen, rsize, rburst, $urandom_range(0, 2), $urandom_range(0, 2), d0, resp);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
